// File: rtl/cp0_reg_if.sv
// CP0 register-file access port: WB-stage write (we/addr/data) and execute-stage read (addr/data).
// The master drives the pipeline side, the slave is the register file.
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;

    modport master (output we_i, output waddr_i, output wdata_i, output raddr_i, input data_o);
    modport slave  (input we_i, input waddr_i, input wdata_i, input raddr_i, output data_o);
endinterface

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file (Count/Compare/Status/Cause/EPC/PRId/Config) with timer interrupt.
// Writes and exception updates land in one cycle; reads are combinational. Timer gated by CP0_TIMER_EN.
module cp0_reg (
    input  logic        clk,
    input  logic        rst,
    cp0_reg_if.slave    bus,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);
    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_STATUS  = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;
    localparam logic [4:0]  ADDR_CONFIG  = 5'd16;
    localparam logic [31:0] STATUS_RST   = 32'h1000_0000;
    localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;
    localparam logic [31:0] PRID_VAL     = 32'h004C_0102;
    localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;
    localparam int          EXL          = 1;
    localparam int          BD           = 31;

    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
    logic [31:0] count_w, compare_w;
    logic        timer_w;
    logic [31:0] rdata;
    logic        exc_take;
    logic [4:0]  exc_code;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        timer_q, timer_d;

    // Match is evaluated on the pre-write Count; a Compare write always clears the request.
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        timer_d   = timer_q;
        if (compare_q != 32'd0 && count_q == compare_q) timer_d = 1'b1;
        if (bus.we_i && bus.waddr_i == ADDR_COUNT) count_d = bus.wdata_i;
        if (bus.we_i && bus.waddr_i == ADDR_COMPARE) begin
            compare_d = bus.wdata_i;
            timer_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign count_w   = count_q;
    assign compare_w = compare_q;
    assign timer_w   = timer_q;
`else
    assign count_w   = '0;
    assign compare_w = '0;
    assign timer_w   = 1'b0;
`endif

    always_comb begin
        exc_take = 1'b0;
        exc_code = 5'd0;
        case (excepttype_i)
            32'h0000_0001: exc_take = 1'b1;
            32'h0000_0008, 32'h0000_000A, 32'h0000_000C, 32'h0000_000D: begin
                exc_take = 1'b1;
                exc_code = excepttype_i[4:0];
            end
            default: ;
        endcase
    end

    // Software write first, then interrupt sampling, then exception fields override.
    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        if (bus.we_i) begin
            case (bus.waddr_i)
                ADDR_STATUS: status_d = bus.wdata_i;
                ADDR_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK);
                ADDR_EPC:    epc_d    = bus.wdata_i;
                default: ;
            endcase
        end
        cause_d[15:10] = int_i;
        if (exc_take) begin
            if (!status_q[EXL]) begin
                if (is_in_delayslot_i) begin
                    epc_d       = current_inst_addr_i - 32'd4;
                    cause_d[BD] = 1'b1;
                end else begin
                    epc_d       = current_inst_addr_i;
                    cause_d[BD] = 1'b0;
                end
            end
            status_d[EXL] = 1'b1;
            cause_d[6:2]  = exc_code;
        end else if (excepttype_i == 32'h0000_000E) begin
            status_d[EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= STATUS_RST;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.raddr_i)
            ADDR_COUNT:   rdata = count_w;
            ADDR_COMPARE: rdata = compare_w;
            ADDR_STATUS:  rdata = status_q;
            ADDR_CAUSE:   rdata = cause_q;
            ADDR_EPC:     rdata = epc_q;
            ADDR_PRID:    rdata = PRID_VAL;
            ADDR_CONFIG:  rdata = CONFIG_VAL;
            default: ;
        endcase
    end

    assign bus.data_o  = rdata;
    assign count_o     = count_w;
    assign compare_o   = compare_w;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = CONFIG_VAL;
    assign prid_o      = PRID_VAL;
    assign timer_int_o = timer_w;
endmodule

// File: tb/tb_cp0_reg.sv
// Bench for cp0_reg: stimulus pushes expected post-edge state into a queue, a monitor pops and compares.
// Works with or without CP0_TIMER_EN defined.
module tb_cp0_reg;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_reg_if bus ();
    logic [5:0]  int_i;
    logic [31:0] excepttype_i, current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    cp0_reg dut (
        .clk(clk), .rst(rst), .bus(bus),
        .int_i(int_i), .excepttype_i(excepttype_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .count_o(count_o), .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o), .timer_int_o(timer_int_o)
    );

`ifdef CP0_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    localparam logic [31:0] PRID_VAL   = 32'h004C_0102;
    localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

    typedef struct {
        logic [31:0] count, compare, status, cause, epc, rdata;
        logic        timer;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_timer;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            5'd16:   return CONFIG_VAL;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
        m_cause = 0; m_epc = 0; m_timer = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [5:0] irq, input logic [31:0] exc,
                              input logic [31:0] pc, input logic ds);
        logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, code;
        logic        n_timer;
        bool_exc: begin end
        n_count = TIMER_EN ? m_count + 1 : 0;
        n_compare = m_compare; n_timer = m_timer;
        n_status = m_status; n_cause = m_cause; n_epc = m_epc;
        if (TIMER_EN && m_compare != 0 && m_count == m_compare) n_timer = 1'b1;
        if (we) begin
            if (wa == 9 && TIMER_EN) n_count = wd;
            if (wa == 11 && TIMER_EN) begin n_compare = wd; n_timer = 1'b0; end
            if (wa == 12) n_status = wd;
            if (wa == 13) n_cause = (m_cause & 32'hFF3F_FCFF) | (wd & 32'h00C0_0300);
            if (wa == 14) n_epc = wd;
        end
        n_cause = (n_cause & 32'hFFFF_03FF) | ({26'd0, irq} * 32'd1024);
        if (exc == 1 || exc == 8 || exc == 10 || exc == 12 || exc == 13) begin
            if ((m_status & 32'h2) == 0) begin
                n_epc   = ds ? pc - 4 : pc;
                n_cause = ds ? (n_cause | 32'h8000_0000) : (n_cause & 32'h7FFF_FFFF);
            end
            n_status = n_status | 32'h2;
            code = (exc == 1) ? 0 : exc;
            n_cause = (n_cause & 32'hFFFF_FF83) | (code * 4);
        end else if (exc == 14) begin
            n_status = n_status & 32'hFFFF_FFFD;
        end
        m_count = n_count; m_compare = n_compare; m_timer = n_timer;
        m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    endtask

    // Caller is at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [5:0] irq, input logic [31:0] exc,
                         input logic [31:0] pc, input logic ds);
        exp_t e;
        bus.we_i = we; bus.waddr_i = wa; bus.wdata_i = wd; bus.raddr_i = ra;
        int_i = irq; excepttype_i = exc; current_inst_addr_i = pc; is_in_delayslot_i = ds;
        model_step(we, wa, wd, irq, exc, pc, ds);
        e.count = m_count; e.compare = m_compare; e.status = m_status;
        e.cause = m_cause; e.epc = m_epc; e.timer = m_timer; e.rdata = model_read(ra);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] ra);
        cycle(1'b0, 5'd0, 32'd0, ra, 6'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, count_o, 32'd0);
        chk({tag, "_compare"}, compare_o, 32'd0);
        chk({tag, "_status"}, status_o, 32'h1000_0000);
        chk({tag, "_cause"}, cause_o, 32'd0);
        chk({tag, "_epc"}, epc_o, 32'd0);
        chk({tag, "_config"}, config_o, 32'h0000_8000);
        chk({tag, "_prid"}, prid_o, 32'h004C_0102);
        chk({tag, "_timer"}, {31'd0, timer_int_o}, 32'd0);
        chk({tag, "_data_prid"}, bus.data_o, 32'h004C_0102);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_count", count_o, e.count);
            chk("sb_compare", compare_o, e.compare);
            chk("sb_status", status_o, e.status);
            chk("sb_cause", cause_o, e.cause);
            chk("sb_epc", epc_o, e.epc);
            chk("sb_timer", {31'd0, timer_int_o}, {31'd0, e.timer});
            chk("sb_data", bus.data_o, e.rdata);
            chk("sb_prid", prid_o, PRID_VAL);
            chk("sb_config", config_o, CONFIG_VAL);
        end
    end

    initial begin
        logic [31:0] exc_tab [7];
        int rise_at;
        exc_tab[0] = 32'h1; exc_tab[1] = 32'h8; exc_tab[2] = 32'hA; exc_tab[3] = 32'hC;
        exc_tab[4] = 32'hD; exc_tab[5] = 32'hE; exc_tab[6] = 32'h3;

        rst = 1'b1;
        bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = 5'd15;
        int_i = '0; excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        repeat (5) idle(5'd9);
        chk("count_after_5", count_o, TIMER_EN ? 32'd5 : 32'd0);

`ifdef CP0_TIMER_EN
        cycle(1'b1, 5'd11, 32'h20, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 5'd9, 32'h10, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
        rise_at = 0;
        for (int i = 1; i <= 20; i++) begin
            idle(5'd9);
            if (timer_int_o && rise_at == 0) rise_at = i;
        end
        chk("timer_rise_cycle", rise_at, 32'd17);
        cycle(1'b1, 5'd11, 32'h40, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
        chk("timer_clear_on_compare", {31'd0, timer_int_o}, 32'd0);
        cycle(1'b1, 5'd9, 32'hFFFF_FFFE, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
        idle(5'd9);
        idle(5'd9);
        chk("count_wrap", count_o, 32'd0);
`else
        rise_at = 0;
        cycle(1'b1, 5'd9, 32'h55, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0);
        chk("count_write_ignored", count_o, 32'd0);
        cycle(1'b1, 5'd11, 32'h3, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(5'd9);
            if (timer_int_o) rise_at = 1;
        end
        chk("timer_tied_low", rise_at, 32'd0);
`endif

        cycle(1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'h15, 32'd0, 32'd0, 1'b0);
        chk("cause_mask", cause_o, 32'h00C0_5700);

        cycle(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h8, 32'hBFC0_0104, 1'b1);
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("sys_exccode", {27'd0, cause_o[6:2]}, 32'd8);
        chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h8, 32'h8000_0040, 1'b0);
        chk("sys2_epc_kept", epc_o, 32'hBFC0_0100);
        cycle(1'b1, 5'd14, 32'h1234, 5'd12, 6'd0, 32'hE, 32'd0, 1'b0);
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
        chk("eret_epc", epc_o, 32'h0000_1234);

        for (int n = 0; n < 2000; n++) begin
            logic        we, ds;
            logic [4:0]  wa, ra;
            logic [31:0] wd, exc;
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(9, 16));
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(9, 16));
            wd = $urandom;
            if (wa == 5'd11) wd = m_count + $urandom_range(2, 30);
            if (wa == 5'd9 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            exc = 32'd0;
            if ($urandom_range(0, 9) > 6) exc = exc_tab[$urandom_range(0, 6)];
            ds = 1'($urandom_range(0, 1));
            cycle(we, wa, wd, ra, 6'($urandom), exc, $urandom, ds);
        end

        rst = 1'b1;
        #1;
        bus.raddr_i = 5'd15;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        check_reset_values("midrst_hold");
        rst = 1'b0;
        repeat (4) idle(5'd12);
        chk("count_after_midrst", count_o, TIMER_EN ? 32'd4 : 32'd0);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
